// File: rtl/hwpf_stride_snooper_array.sv
// hwpf_stride_snooper_array
// Array of NB_SNOOPERS window snoopers. Each entry holds a base cache line and
// watches NB_PORTS request ports for lines in [base, base+WINDOW_LINES) (modulo
// 2^NLINE_W). Hits are counted per entry; when the count reaches the shared
// threshold, the entry raises a level trigger toward the stride prefetch engine.
// An acknowledge slides the window forward by WINDOW_LINES and re-arms the entry.
//
// Optional build macro: HWPF_SNOOPER_PERF_CNT_EN
//   defined   -> perf_match_cnt_o counts (entry, port) hit pairs, wraps at 2^32
//   undefined -> perf_match_cnt_o is tied to zero, no counter flops
//
// Per-entry FSM state is held in state_q[] (IDLE / ARMED / TRIGGERED) so
// checkers can bind to it directly.
//
// Handshake: trigger_o[i] is a level that stays high while entry i is
// TRIGGERED; the engine pulses trigger_ack_i[i] for one cycle to consume it,
// and trigger_o[i] drops on the following cycle. Acks seen while the entry is
// not TRIGGERED are ignored.
module hwpf_stride_snooper_array #(
  parameter int NLINE_W      = 40,
  parameter int NB_SNOOPERS  = 4,
  parameter int NB_PORTS     = 2,
  parameter int WINDOW_LINES = 4,
  parameter int CNT_W        = 4,
  localparam int IDX_W       = (NB_SNOOPERS > 1) ? $clog2(NB_SNOOPERS) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            cfg_valid_i,
  input  logic [IDX_W-1:0]                cfg_idx_i,
  input  logic                            cfg_en_i,
  input  logic [NLINE_W-1:0]              cfg_base_i,
  input  logic [CNT_W-1:0]                threshold_i,
  input  logic [NB_PORTS-1:0]             snoop_valid_i,
  input  logic [NB_PORTS*NLINE_W-1:0]     snoop_nline_i,
  input  logic [NB_SNOOPERS-1:0]          trigger_ack_i,
  output logic [NB_SNOOPERS-1:0]          match_o,
  output logic [NB_SNOOPERS-1:0]          trigger_o,
  output logic [NB_SNOOPERS*NLINE_W-1:0]  base_o,
  output logic [31:0]                     perf_match_cnt_o
);

  localparam int INC_W = $clog2(NB_PORTS + 1);
  localparam int SUM_W = CNT_W + INC_W;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2
  } state_e;

  state_e                  state_q [NB_SNOOPERS];
  state_e                  state_d [NB_SNOOPERS];
  logic [CNT_W-1:0]        cnt_q   [NB_SNOOPERS];
  logic [CNT_W-1:0]        cnt_d   [NB_SNOOPERS];
  logic [NLINE_W-1:0]      base_q  [NB_SNOOPERS];
  logic [NLINE_W-1:0]      base_d  [NB_SNOOPERS];
  logic [NB_SNOOPERS-1:0]  match_q;
  logic [NB_SNOOPERS-1:0]  match_d;

  logic [NB_PORTS-1:0]     hit     [NB_SNOOPERS];
  logic [INC_W-1:0]        inc     [NB_SNOOPERS];
  logic [CNT_W-1:0]        thr_eff;

  // A zero threshold behaves like one so an armed entry never fires without a hit.
  always_comb begin
    thr_eff = threshold_i;
    if (threshold_i == '0) thr_eff = CNT_W'(1);
  end

  // Window hit detection: unsigned modular offset from each base, per port.
  always_comb begin
    logic [NLINE_W-1:0] offset;
    offset = '0;
    for (int i = 0; i < NB_SNOOPERS; i++) begin
      inc[i] = '0;
      for (int p = 0; p < NB_PORTS; p++) begin
        offset    = snoop_nline_i[p*NLINE_W +: NLINE_W] - base_q[i];
        hit[i][p] = snoop_valid_i[p] && (state_q[i] != ST_IDLE) &&
                    (offset < NLINE_W'(WINDOW_LINES));
        inc[i]    = inc[i] + INC_W'(hit[i][p]);
      end
    end
  end

  // Per-entry next state: cfg write beats ack, ack beats snoop counting.
  always_comb begin
    logic [SUM_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < NB_SNOOPERS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      base_d[i]  = base_q[i];
      // Match reflects this cycle's hits against the current base/state.
      match_d[i] = |hit[i];
      sum        = SUM_W'(cnt_q[i]) + SUM_W'(inc[i]);

      if (cfg_valid_i && (cfg_idx_i == IDX_W'(i))) begin
        cnt_d[i] = '0;
        if (cfg_en_i) begin
          base_d[i]  = cfg_base_i;
          state_d[i] = ST_ARMED;
        end else begin
          state_d[i] = ST_IDLE;
        end
      end else begin
        unique case (state_q[i])
          ST_ARMED: begin
            if (sum > SUM_W'({CNT_W{1'b1}})) cnt_d[i] = {CNT_W{1'b1}};
            else                             cnt_d[i] = sum[CNT_W-1:0];
            // Requires a hit this cycle, so a lowered threshold fires on the next hit.
            if ((inc[i] != '0) && (sum >= SUM_W'(thr_eff))) state_d[i] = ST_TRIGGERED;
          end
          ST_TRIGGERED: begin
            if (trigger_ack_i[i]) begin
              base_d[i]  = base_q[i] + NLINE_W'(WINDOW_LINES);
              cnt_d[i]   = '0;
              state_d[i] = ST_ARMED;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Entry state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NB_SNOOPERS; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        base_q[i]  <= '0;
      end
      match_q <= '0;
    end else begin
      for (int i = 0; i < NB_SNOOPERS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        base_q[i]  <= base_d[i];
      end
      match_q <= match_d;
    end
  end

  assign match_o = match_q;

  for (genvar g = 0; g < NB_SNOOPERS; g++) begin : g_out
    assign trigger_o[g]                   = (state_q[g] == ST_TRIGGERED);
    assign base_o[g*NLINE_W +: NLINE_W]   = base_q[g];
  end

`ifdef HWPF_SNOOPER_PERF_CNT_EN
  logic [31:0] perf_q;
  logic [31:0] perf_d;

  // Accumulate every (entry, port) hit pair; wraps naturally at 2^32.
  always_comb begin
    perf_d = perf_q;
    for (int i = 0; i < NB_SNOOPERS; i++) begin
      for (int p = 0; p < NB_PORTS; p++) begin
        perf_d = perf_d + 32'(hit[i][p]);
      end
    end
  end

  // Performance counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_match_cnt_o = perf_q;
`else
  assign perf_match_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hwpf_stride_snooper_array.sv
// Directed bench for hwpf_stride_snooper_array. The driver issues one cycle of
// stimulus at a time and pushes the hand-computed outputs expected after that
// clock edge; a separate monitor pops and compares on the falling edge.
module tb_hwpf_stride_snooper_array;

  localparam int NLINE_W = 40;
  localparam int NB      = 4;
  localparam int NP      = 2;
  localparam int WL      = 4;
  localparam int CNT_W   = 4;
  localparam int EXP_W   = NB + NB + NB*NLINE_W + 32;

  logic                     clk_i;
  logic                     rst_i;
  logic                     cfg_valid_i;
  logic [1:0]               cfg_idx_i;
  logic                     cfg_en_i;
  logic [NLINE_W-1:0]       cfg_base_i;
  logic [CNT_W-1:0]         threshold_i;
  logic [NP-1:0]            snoop_valid_i;
  logic [NP*NLINE_W-1:0]    snoop_nline_i;
  logic [NB-1:0]            trigger_ack_i;
  logic [NB-1:0]            match_o;
  logic [NB-1:0]            trigger_o;
  logic [NB*NLINE_W-1:0]    base_o;
  logic [31:0]              perf_match_cnt_o;

  hwpf_stride_snooper_array #(
    .NLINE_W(NLINE_W), .NB_SNOOPERS(NB), .NB_PORTS(NP),
    .WINDOW_LINES(WL), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_idx_i(cfg_idx_i), .cfg_en_i(cfg_en_i),
    .cfg_base_i(cfg_base_i), .threshold_i(threshold_i),
    .snoop_valid_i(snoop_valid_i), .snoop_nline_i(snoop_nline_i),
    .trigger_ack_i(trigger_ack_i), .match_o(match_o), .trigger_o(trigger_o),
    .base_o(base_o), .perf_match_cnt_o(perf_match_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0]   exp_q[$];
  int                 tag_q[$];
  int                 total = 0;
  int                 bad   = 0;
  int                 step_no = 0;

  logic [NB-1:0]      em;
  logic [NB-1:0]      et;
  logic [NLINE_W-1:0] eb [NB];
  logic [31:0]        ep;

  function automatic logic [EXP_W-1:0] pack_exp();
    logic [EXP_W-1:0] v;
    v = '0;
    v[EXP_W-1 -: NB]      = em;
    v[EXP_W-NB-1 -: NB]   = et;
    for (int i = 0; i < NB; i++) v[32 + i*NLINE_W +: NLINE_W] = eb[i];
    v[31:0] = ep;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input int pairs);
    @(posedge clk_i);
`ifdef HWPF_SNOOPER_PERF_CNT_EN
    if (rst_i) ep = 32'd0;
    else       ep = ep + 32'(pairs);
`else
    ep = 32'd0;
    if (pairs < 0) ep = 32'd0;
`endif
    exp_q.push_back(pack_exp());
    tag_q.push_back(step_no);
    step_no++;
    @(negedge clk_i);
    rst_i         = 1'b0;
    cfg_valid_i   = 1'b0;
    snoop_valid_i = '0;
    trigger_ack_i = '0;
  endtask

  task automatic cfg(input int idx, input logic en, input logic [NLINE_W-1:0] base);
    cfg_valid_i = 1'b1;
    cfg_idx_i   = 2'(idx);
    cfg_en_i    = en;
    cfg_base_i  = base;
  endtask

  task automatic snoop(input int port, input logic [NLINE_W-1:0] nline);
    snoop_valid_i[port]                      = 1'b1;
    snoop_nline_i[port*NLINE_W +: NLINE_W]   = nline;
  endtask

  task automatic chk(input string nm, input int tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL step%0d %s: got %h expected %h", tag, nm, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      int t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk("match",   t, 64'(match_o),   64'(e[EXP_W-1 -: NB]));
      chk("trigger", t, 64'(trigger_o), 64'(e[EXP_W-NB-1 -: NB]));
      for (int i = 0; i < NB; i++)
        chk($sformatf("base%0d", i), t, 64'(base_o[i*NLINE_W +: NLINE_W]),
            64'(e[32 + i*NLINE_W +: NLINE_W]));
      chk("perf", t, 64'(perf_match_cnt_o), 64'(e[31:0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_idx_i = '0; cfg_en_i = 1'b0;
    cfg_base_i = '0; threshold_i = 4'd3; snoop_valid_i = '0;
    snoop_nline_i = '0; trigger_ack_i = '0;
    em = '0; et = '0; ep = '0;
    for (int i = 0; i < NB; i++) eb[i] = '0;

    // Reset: everything zero.
    rst_i = 1'b1; cycle(0);
    rst_i = 1'b1; cycle(0);

    // 1: entry 0, base 0x100, threshold 3, three single-port hits.
    cfg(0, 1'b1, 40'h100); eb[0] = 40'h100; cycle(0);
    snoop(0, 40'h100); em = 4'b0001; cycle(1);
    snoop(0, 40'h102); em = 4'b0001; cycle(1);
    snoop(0, 40'h103); em = 4'b0001; et = 4'b0001; cycle(1);
    em = 4'b0000; cycle(0);
    trigger_ack_i[0] = 1'b1; eb[0] = 40'h104; et = 4'b0000; cycle(0);
    cycle(0);

    // 2: entry 1, base 0x200, threshold 2, two ports hit in one cycle.
    threshold_i = 4'd2;
    cfg(1, 1'b1, 40'h200); eb[1] = 40'h200; cycle(0);
    snoop(0, 40'h201); snoop(1, 40'h203); em = 4'b0010; et = 4'b0010; cycle(2);
    snoop(0, 40'h204); snoop(1, 40'h1FF); em = 4'b0000; cycle(0);
    trigger_ack_i[1] = 1'b1; eb[1] = 40'h204; et = 4'b0000; cycle(0);

    // 3: wrap-around window on entry 2.
    cfg(2, 1'b1, 40'hFF_FFFF_FFFE); eb[2] = 40'hFF_FFFF_FFFE; cycle(0);
    snoop(0, 40'h01); em = 4'b0100; cycle(1);
    snoop(0, 40'h04); em = 4'b0000; cycle(0);

    // 4: trigger entry 2, then cfg + ack + hit together; cfg wins.
    snoop(0, 40'hFF_FFFF_FFFE); em = 4'b0100; et = 4'b0100; cycle(1);
    cfg(2, 1'b1, 40'h500); trigger_ack_i[2] = 1'b1; snoop(0, 40'hFF_FFFF_FFFF);
    em = 4'b0100; et = 4'b0000; eb[2] = 40'h500; cycle(1);
    snoop(0, 40'h501); em = 4'b0100; cycle(1);           // count restarted at 0
    snoop(0, 40'h502); em = 4'b0100; et = 4'b0100; cycle(1);
    trigger_ack_i[2] = 1'b1; em = 4'b0000; et = 4'b0000; eb[2] = 40'h504; cycle(0);

    // Lowered threshold only fires on the next hit; threshold 0 acts as 1.
    threshold_i = 4'd4;
    snoop(0, 40'h504); snoop(1, 40'h505); em = 4'b0100; cycle(2);
    threshold_i = 4'd1; em = 4'b0000; cycle(0);
    snoop(1, 40'h506); em = 4'b0100; et = 4'b0100; cycle(1);
    trigger_ack_i[2] = 1'b1; em = 4'b0000; et = 4'b0000; eb[2] = 40'h508; cycle(0);
    threshold_i = 4'd0;
    snoop(1, 40'h508); em = 4'b0100; et = 4'b0100; cycle(1);
    trigger_ack_i[2] = 1'b1; em = 4'b0000; et = 4'b0000; eb[2] = 40'h50C; cycle(0);
    threshold_i = 4'd2;

    // 5: disable entry 0, base retained, no match; acks in IDLE/ARMED ignored.
    cfg(0, 1'b0, 40'h999); cycle(0);
    snoop(0, 40'h104); cycle(0);
    trigger_ack_i[0] = 1'b1; trigger_ack_i[1] = 1'b1; cycle(0);
    snoop(0, 40'h50C); snoop(1, 40'h50D); em = 4'b0100; et = 4'b0100; cycle(2);
    rst_i = 1'b1; em = '0; et = '0; for (int i = 0; i < NB; i++) eb[i] = '0; cycle(0);

    // 6: overlapping windows, both ports hitting both entries for 5 cycles.
    threshold_i = 4'd15;
    cfg(0, 1'b1, 40'h10); eb[0] = 40'h10; cycle(0);
    cfg(1, 1'b1, 40'h12); eb[1] = 40'h12; cycle(0);
    for (int k = 0; k < 5; k++) begin
      snoop(0, 40'h12); snoop(1, 40'h13); em = 4'b0011; cycle(4);
    end
    em = 4'b0000; cycle(0);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk_i);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
